// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259-style PIC host sequencer.
// Holds the FSM state encoding and the default init/EOI command words.
package pic_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    READY,
    INTA1,
    INTA_GAP,
    INTA2,
    VEC_WAIT
  } state_t;

  localparam logic [7:0] OCW2_NSEOI   = 8'h20;
  localparam logic [7:0] ICW1_DEFAULT = 8'h13;
  localparam logic [7:0] ICW2_DEFAULT = 8'h20;
  localparam logic [7:0] ICW4_DEFAULT = 8'h01;
  localparam logic [7:0] OCW1_DEFAULT = 8'h00;

endpackage

// File: rtl/pic_strobe_timer.sv
// Down-counter that times the width of one low strobe pulse.
// done is high on the final cycle of the pulse; load arms it for CYCLES cycles.
module pic_strobe_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam logic [3:0] LOAD_VAL = 4'(CYCLES - 1);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 4'd0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (count && (cnt_reg != 4'd0)) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  assign done = (cnt_reg == 4'd0);

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259-style PIC: writes the init words, runs the
// two-pulse INTA cycle to fetch a vector, and issues non-specific EOIs.
module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter logic [7:0]  ICW1_VAL      = ICW1_DEFAULT,
  parameter logic [7:0]  ICW2_VAL      = ICW2_DEFAULT,
  parameter logic [7:0]  ICW4_VAL      = ICW4_DEFAULT,
  parameter logic [7:0]  OCW1_VAL      = OCW1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       init_done,
  input  logic       eoi_req,
  input  logic       pic_int,
  output logic       pic_cs_n,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_inta_n,
  output logic       pic_a0,
  output logic [7:0] pic_d_out,
  output logic       pic_d_oe,
  input  logic [7:0] pic_d_in,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready
);

  state_t      state_reg, state_next;
  logic [1:0]  rst_sync_reg;
  logic        rst_int_n;
  logic [1:0]  word_reg, word_next;
  logic        eoi_wr_reg, eoi_wr_next;
  logic        eoi_pend_reg, eoi_pend_next;
  logic        init_done_next, a0_next, vec_valid_next;
  logic [7:0]  d_out_next, vec_data_next;
  logic        tmr_load, tmr_count, tmr_done;
  logic        in_write;

  // Reset asserts immediately but releases only after two clean clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  pic_strobe_timer #(.CYCLES(STROBE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_int_n),
    .load  (tmr_load),
    .count (tmr_count),
    .done  (tmr_done)
  );

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = {1'b0, ICW1_VAL};
      2'd1:    init_word = {1'b1, ICW2_VAL};
      2'd2:    init_word = {1'b1, ICW4_VAL};
      default: init_word = {1'b1, OCW1_VAL};
    endcase
  endfunction

  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    eoi_wr_next    = eoi_wr_reg;
    eoi_pend_next  = eoi_pend_reg | eoi_req;
    init_done_next = init_done;
    a0_next        = pic_a0;
    d_out_next     = pic_d_out;
    vec_valid_next = vec_valid;
    vec_data_next  = vec_data;
    tmr_load       = 1'b0;
    tmr_count      = 1'b0;
    case (state_reg)
      IDLE, READY: begin
        if (start) begin
          state_next             = WR_SETUP;
          word_next              = 2'd0;
          eoi_wr_next            = 1'b0;
          init_done_next         = 1'b0;
          {a0_next, d_out_next}  = init_word(2'd0);
        end else if (state_reg == READY && eoi_pend_reg) begin
          // A new eoi_req on the acceptance cycle is kept as a fresh request.
          state_next    = WR_SETUP;
          eoi_wr_next   = 1'b1;
          eoi_pend_next = eoi_req;
          a0_next       = 1'b0;
          d_out_next    = OCW2_NSEOI;
        end else if (state_reg == READY && init_done && pic_int) begin
          state_next = INTA1;
          tmr_load   = 1'b1;
        end
      end
      WR_SETUP: begin
        state_next = WR_STROBE;
        tmr_load   = 1'b1;
      end
      WR_STROBE: begin
        tmr_count = 1'b1;
        if (tmr_done) state_next = WR_HOLD;
      end
      WR_HOLD: begin
        if (eoi_wr_reg || word_reg == 2'd3) begin
          state_next = READY;
          if (!eoi_wr_reg) init_done_next = 1'b1;
        end else begin
          state_next            = WR_SETUP;
          word_next             = word_reg + 2'd1;
          {a0_next, d_out_next} = init_word(word_reg + 2'd1);
        end
      end
      INTA1: begin
        tmr_count = 1'b1;
        if (tmr_done) state_next = INTA_GAP;
      end
      INTA_GAP: begin
        state_next = INTA2;
        tmr_load   = 1'b1;
      end
      INTA2: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_next     = VEC_WAIT;
          vec_valid_next = 1'b1;
          vec_data_next  = pic_d_in;
        end
      end
      VEC_WAIT: begin
        if (vec_ready) begin
          state_next     = READY;
          vec_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register in step with it.
  assign in_write = (state_next == WR_SETUP) || (state_next == WR_STROBE) ||
                    (state_next == WR_HOLD);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg    <= IDLE;
      word_reg     <= 2'd0;
      eoi_wr_reg   <= 1'b0;
      eoi_pend_reg <= 1'b0;
      busy         <= 1'b0;
      init_done    <= 1'b0;
      pic_cs_n     <= 1'b1;
      pic_wr_n     <= 1'b1;
      pic_rd_n     <= 1'b1;
      pic_inta_n   <= 1'b1;
      pic_a0       <= 1'b0;
      pic_d_out    <= 8'h00;
      pic_d_oe     <= 1'b0;
      vec_valid    <= 1'b0;
      vec_data     <= 8'h00;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      eoi_wr_reg   <= eoi_wr_next;
      eoi_pend_reg <= eoi_pend_next;
      busy         <= (state_next != IDLE) && (state_next != READY);
      init_done    <= init_done_next;
      pic_cs_n     <= !in_write;
      pic_wr_n     <= (state_next != WR_STROBE);
      pic_rd_n     <= 1'b1;
      pic_inta_n   <= !((state_next == INTA1) || (state_next == INTA2));
      pic_a0       <= a0_next;
      pic_d_out    <= d_out_next;
      pic_d_oe     <= in_write;
      vec_valid    <= vec_valid_next;
      vec_data     <= vec_data_next;
    end
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer with STROBE_CYCLES=2: init writes,
// INTA vector fetch, vector hold, EOI priority/coalescing and mid-sequence reset.
module tb_pic_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, eoi_req, pic_int, vec_ready;
  logic [7:0] pic_d_in;
  logic       busy, init_done, pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n, pic_a0;
  logic       pic_d_oe, vec_valid;
  logic [7:0] pic_d_out, vec_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pic_host_sequencer #(.STROBE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .init_done  (init_done),
    .eoi_req    (eoi_req),
    .pic_int    (pic_int),
    .pic_cs_n   (pic_cs_n),
    .pic_wr_n   (pic_wr_n),
    .pic_rd_n   (pic_rd_n),
    .pic_inta_n (pic_inta_n),
    .pic_a0     (pic_a0),
    .pic_d_out  (pic_d_out),
    .pic_d_oe   (pic_d_oe),
    .pic_d_in   (pic_d_in),
    .vec_valid  (vec_valid),
    .vec_data   (vec_data),
    .vec_ready  (vec_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; eoi_req = 1'b0; pic_int = 1'b0;
    vec_ready = 1'b0; pic_d_in = 8'h00;
    #12;
    n_checks++;
    if ({pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 1111", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n});
    end
    n_checks++;
    if ({pic_a0, pic_d_oe, pic_d_out, busy, init_done, vec_valid, vec_data} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: a0=%b oe=%b d=%02h busy=%b done=%b vv=%b vd=%02h required all zero",
               pic_a0, pic_d_oe, pic_d_out, busy, init_done, vec_valid, vec_data);
    end
    tick();
    rst_n = 1'b1;
    pic_int = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (pic_inta_n !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_int_ignored cyc%0d: inta_n=%b busy=%b required inta_n=1 busy=0", i, pic_inta_n, busy);
      end
    end
    pic_int = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_init();
    logic [7:0] exp_d[4];
    logic       exp_a0[4];
    exp_d  = '{8'h13, 8'h20, 8'h01, 8'h00};
    exp_a0 = '{1'b0, 1'b1, 1'b1, 1'b1};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      int   w;
      int   p;
      logic ew;
      w  = k / 4;
      p  = k % 4;
      ew = (p == 1 || p == 2) ? 1'b0 : 1'b1;
      n_checks++;
      if (pic_cs_n !== 1'b0 || pic_wr_n !== ew || pic_a0 !== exp_a0[w] || pic_d_out !== exp_d[w] ||
          pic_d_oe !== 1'b1 || busy !== 1'b1 || init_done !== 1'b0 || pic_inta_n !== 1'b1) begin
        n_fail++;
        $display("FAIL init_cyc%0d: cs_n=%b wr_n=%b a0=%b d=%02h oe=%b busy=%b done=%b required cs_n=0 wr_n=%b a0=%b d=%02h oe=1 busy=1 done=0",
                 k, pic_cs_n, pic_wr_n, pic_a0, pic_d_out, pic_d_oe, busy, init_done, ew, exp_a0[w], exp_d[w]);
      end
      if (p == 3) $display("init write: a0=%0d data=%02h", pic_a0, pic_d_out);
      tick();
    end
    n_checks++;
    if (init_done !== 1'b1 || pic_cs_n !== 1'b1 || pic_d_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_end: done=%b cs_n=%b oe=%b busy=%b required done=1 cs_n=1 oe=0 busy=0",
               init_done, pic_cs_n, pic_d_oe, busy);
    end
  endtask

  task automatic test_inta();
    logic exp_inta[5];
    exp_inta = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pic_d_in = 8'hFF;
    pic_int  = 1'b1;
    tick();
    pic_int = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) pic_d_in = 8'h23;
      n_checks++;
      if (pic_inta_n !== exp_inta[i] || pic_cs_n !== 1'b1 || busy !== 1'b1 || vec_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL inta_cyc%0d: inta_n=%b cs_n=%b busy=%b vv=%b required inta_n=%b cs_n=1 busy=1 vv=0",
                 i, pic_inta_n, pic_cs_n, busy, vec_valid, exp_inta[i]);
      end
      tick();
    end
    pic_d_in = 8'hFF;
    n_checks++;
    if (vec_valid !== 1'b1 || vec_data !== 8'h23 || pic_inta_n !== 1'b1) begin
      n_fail++;
      $display("FAIL inta_vector: vv=%b vd=%02h inta_n=%b required vv=1 vd=23 inta_n=1", vec_valid, vec_data, pic_inta_n);
    end
    $display("inta: vector=%02h", vec_data);
  endtask

  task automatic test_vec_hold();
    pic_int   = 1'b1;
    vec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (vec_valid !== 1'b1 || vec_data !== 8'h23 || pic_inta_n !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL vec_hold_cyc%0d: vv=%b vd=%02h inta_n=%b busy=%b required vv=1 vd=23 inta_n=1 busy=1",
                 i, vec_valid, vec_data, pic_inta_n, busy);
      end
    end
    pic_int   = 1'b0;
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    n_checks++;
    if (vec_valid !== 1'b0 || busy !== 1'b0 || pic_inta_n !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_handshake: vv=%b busy=%b inta_n=%b required vv=0 busy=0 inta_n=1", vec_valid, busy, pic_inta_n);
    end
    $display("vec_hold: handshake complete");
  endtask

  task automatic test_eoi_priority();
    pic_d_in = 8'h24;
    pic_int  = 1'b1;
    tick();                                    // i=0 INTA1
    eoi_req = 1'b1; tick(); eoi_req = 1'b0;   // i=1
    tick();                                    // i=2 gap
    eoi_req = 1'b1; tick(); eoi_req = 1'b0;   // i=3, coalesced second request
    tick();                                    // i=4
    tick();                                    // i=5 VEC_WAIT
    n_checks++;
    if (vec_valid !== 1'b1 || vec_data !== 8'h24) begin
      n_fail++;
      $display("FAIL eoi_vector: vv=%b vd=%02h required vv=1 vd=24", vec_valid, vec_data);
    end
    vec_ready = 1'b1;
    tick();                                    // i=6 READY
    vec_ready = 1'b0;
    tick();                                    // i=7 WR_SETUP for OCW2
    n_checks++;
    if (pic_cs_n !== 1'b0 || pic_a0 !== 1'b0 || pic_d_out !== 8'h20 || pic_d_oe !== 1'b1 ||
        pic_inta_n !== 1'b1 || pic_wr_n !== 1'b1) begin
      n_fail++;
      $display("FAIL eoi_setup: cs_n=%b a0=%b d=%02h oe=%b inta_n=%b wr_n=%b required cs_n=0 a0=0 d=20 oe=1 inta_n=1 wr_n=1",
               pic_cs_n, pic_a0, pic_d_out, pic_d_oe, pic_inta_n, pic_wr_n);
    end
    for (int i = 8; i < 10; i++) begin
      tick();
      n_checks++;
      if (pic_wr_n !== 1'b0 || pic_cs_n !== 1'b0 || pic_d_out !== 8'h20) begin
        n_fail++;
        $display("FAIL eoi_strobe_cyc%0d: wr_n=%b cs_n=%b d=%02h required wr_n=0 cs_n=0 d=20", i, pic_wr_n, pic_cs_n, pic_d_out);
      end
    end
    tick();                                    // i=10 WR_HOLD
    tick();                                    // i=11 READY
    n_checks++;
    if (pic_cs_n !== 1'b1 || busy !== 1'b0 || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL eoi_end: cs_n=%b busy=%b done=%b required cs_n=1 busy=0 done=1", pic_cs_n, busy, init_done);
    end
    $display("eoi: OCW2 a0=0 data=20 written");
    tick();                                    // i=12 new INTA, not a second EOI
    n_checks++;
    if (pic_inta_n !== 1'b0 || pic_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL eoi_coalesce: inta_n=%b cs_n=%b required inta_n=0 cs_n=1", pic_inta_n, pic_cs_n);
    end
    pic_int   = 1'b0;
    vec_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    vec_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || vec_valid !== 1'b0 || vec_data !== 8'h24) begin
      n_fail++;
      $display("FAIL eoi_drain: busy=%b vv=%b vd=%02h required busy=0 vv=0 vd=24", busy, vec_valid, vec_data);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (init_done !== 1'b0 || pic_d_out !== 8'h13) begin
      n_fail++;
      $display("FAIL restart_clear: done=%b d=%02h required done=0 d=13", init_done, pic_d_out);
    end
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;       // k=3, mid-sequence start
    for (int k = 3; k < 16; k++) tick();
    n_checks++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored_end: done=%b busy=%b required done=1 busy=0", init_done, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || pic_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored_norestart: busy=%b cs_n=%b required busy=0 cs_n=1", busy, pic_cs_n);
    end
    $display("start_ignored: sequence length unchanged");
  endtask

  task automatic test_reset_midseq();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();        // k=5: ICW2 WR_STROBE
    n_checks++;
    if (pic_wr_n !== 1'b0 || pic_cs_n !== 1'b0 || pic_d_out !== 8'h20) begin
      n_fail++;
      $display("FAIL midseq_pre: wr_n=%b cs_n=%b d=%02h required wr_n=0 cs_n=0 d=20", pic_wr_n, pic_cs_n, pic_d_out);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (pic_wr_n !== 1'b1 || pic_cs_n !== 1'b1 || init_done !== 1'b0 || busy !== 1'b0 || pic_d_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL midseq_async: wr_n=%b cs_n=%b done=%b busy=%b oe=%b required wr_n=1 cs_n=1 done=0 busy=0 oe=0",
               pic_wr_n, pic_cs_n, init_done, busy, pic_d_oe);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (pic_cs_n !== 1'b1 || pic_wr_n !== 1'b1 || busy !== 1'b0 || init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midseq_quiet_cyc%0d: cs_n=%b wr_n=%b busy=%b done=%b required cs_n=1 wr_n=1 busy=0 done=0",
                 i, pic_cs_n, pic_wr_n, busy, init_done);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (pic_cs_n !== 1'b0 || pic_a0 !== 1'b0 || pic_d_out !== 8'h13) begin
      n_fail++;
      $display("FAIL midseq_restart: cs_n=%b a0=%b d=%02h required cs_n=0 a0=0 d=13", pic_cs_n, pic_a0, pic_d_out);
    end
    for (int k = 0; k < 16; k++) tick();
    n_checks++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midseq_redone: done=%b busy=%b required done=1 busy=0", init_done, busy);
    end
    $display("reset_midseq: aborted and re-initialised");
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (pic_rd_n !== 1'b1 || (pic_cs_n === 1'b0 && pic_inta_n === 1'b0))) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_invariant: rd_n=%b cs_n=%b inta_n=%b required rd_n=1 and not cs_n=inta_n=0",
               pic_rd_n, pic_cs_n, pic_inta_n);
    end
  end

  initial begin
    test_reset();
    test_init();
    test_inta();
    test_vec_hold();
    test_eoi_priority();
    test_start_ignored();
    test_reset_midseq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_host_sequencer.md
PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

Interface
REQ-001 The block SHALL have the parameter STROBE_CYCLES, default 2, which sets the width in clk cycles of each WR or INTA low pulse (legal range 1..15).
REQ-002 The block SHALL have the parameters ICW1_VAL 8'h13, ICW2_VAL 8'h20, ICW4_VAL 8'h01 and OCW1_VAL 8'h00, which are the init words for single, edge, ICW4-needed mode.
REQ-003 The block SHALL have the following ports:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  start  in  1  one-cycle pulse that begins the init sequence
  busy  out  1  high while any bus sequence is in progress
  init_done  out  1  high once all four init words are written
  eoi_req  in  1  one-cycle pulse requesting a non-specific EOI
  pic_int  in  1  INT output of the PIC
  pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n  out  1 each  active-low PIC strobes
  pic_a0  out  1  PIC address bit
  pic_d_out  out  8  write data to the PIC
  pic_d_oe  out  1  drive enable for pic_d_out
  pic_d_in  in  8  data bus read back from the PIC
  vec_valid  out  1  a captured vector is available
  vec_data  out  8  the captured vector
  vec_ready  in  1  consumer accepts the vector

Function
REQ-004 The FSM SHALL have the states IDLE, WR_SETUP, WR_STROBE, WR_HOLD, READY, INTA1, INTA_GAP, INTA2 and VEC_WAIT.
REQ-005 The bus write cycle SHALL be:
  - WR_SETUP, 1 cycle: pic_cs_n=0, pic_a0 and pic_d_out valid, pic_d_oe=1.
  - WR_STROBE, STROBE_CYCLES cycles: pic_wr_n=0.
  - WR_HOLD, 1 cycle: pic_wr_n=1, pic_cs_n, pic_a0 and data still held.
  - After WR_HOLD: pic_cs_n=1 and pic_d_oe=0.
REQ-006 A start pulse in IDLE or READY SHALL write ICW1 (a0=0), ICW2 (a0=1), ICW4 (a0=1) and OCW1 (a0=1), in that order, each as one REQ-005 cycle with no idle cycle between words, then go to READY.
REQ-007 init_done SHALL clear on the cycle that start is accepted, and SHALL set on entry to READY after OCW1.
REQ-008 A start pulse SHALL be ignored in every state other than IDLE and READY.
REQ-009 pic_int SHALL be ignored unless the FSM is in READY with init_done=1.
REQ-010 The INTA sequence SHALL be:
  - INTA1: pic_inta_n=0 for STROBE_CYCLES cycles.
  - INTA_GAP: pic_inta_n=1 for 1 cycle.
  - INTA2: pic_inta_n=0 for STROBE_CYCLES cycles.
  - pic_d_in is sampled into vec_data on the last INTA2 cycle.
  - Then VEC_WAIT with vec_valid=1.
REQ-011 vec_valid and vec_data SHALL stay stable until a cycle where vec_valid and vec_ready are both high; the FSM then returns to READY.
REQ-012 An eoi_req pulse arriving in any state SHALL set a pending flag; repeated pulses while pending SHALL coalesce into one EOI.
REQ-013 In READY, a pending EOI SHALL take priority over pic_int; it is serviced as one REQ-005 write of OCW2=8'h20 with a0=0, and the pending flag clears on entry to WR_SETUP.
REQ-014 pic_rd_n SHALL be held at 1 at all times.
REQ-015 pic_cs_n and pic_inta_n SHALL never be low in the same cycle.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-017 busy SHALL be 0 only in IDLE and READY.

Reset
REQ-018 On rst_n=0 the block SHALL asynchronously enter IDLE with these values:
  - pic_cs_n, pic_wr_n, pic_rd_n and pic_inta_n = 1
  - pic_a0, pic_d_oe and pic_d_out = 0
  - busy, init_done, vec_valid and vec_data = 0
  - EOI pending flag and strobe counter = 0
REQ-019 Reset asserted mid-sequence SHALL abort the sequence at once with no further strobe; deassertion SHALL be synchronous to clk through a 2-flop synchroniser.

Structure
REQ-020 A shared package pic_host_pkg SHALL hold the state enum, the OCW2_NSEOI constant (8'h20) and the default init-word constants.
REQ-021 The strobe-width counter SHALL be a sub-module, pic_strobe_timer, with load, count and done signals, reused by both the write and the INTA paths.

Verification
REQ-022 With STROBE_CYCLES=2, a start pulse SHALL produce writes of 13/20/01/00 with a0 sequence 0,1,1,1, each pic_wr_n low for exactly 2 cycles, and init_done high 16 cycles after start.
REQ-023 Driving pic_int=1 with pic_d_in=8'h23 during INTA2 SHALL give two 2-cycle INTA pulses separated by a 1-cycle gap, then vec_valid=1 with vec_data=8'h23.
REQ-024 With vec_ready held at 0 for 10 cycles, vec_valid/vec_data SHALL stay stable and no third INTA pulse SHALL occur; after handshake the FSM SHALL return to READY.
REQ-025 Pulsing eoi_req during INTA1 while pic_int stays high SHALL make the next bus cycle after the vector handshake an OCW2 write of 8'h20 with a0=0, before any new INTA.
REQ-026 Asserting rst_n=0 during the WR_STROBE of ICW2 SHALL raise pic_wr_n and pic_cs_n immediately, clear init_done, and cause no further writes until a new start pulse.
